// File: rtl/mips_pkg.sv
// Shared encodings and constants for the MIPS instruction-fetch stage.
package mips_pkg;

  // Next-PC source select driven by the ID stage.
  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_JR     = 2'b11
  } pc_src_t;

  localparam logic [5:0]  OPCODE_HALT  = 6'b111111;
  localparam logic [31:0] INST_NOP     = 32'h0000_0000;
  localparam int unsigned PC_INCREMENT = 32'd4;

  // True when the opcode field encodes the debug HALT instruction.
  function automatic logic is_halt_opcode(input logic [5:0] opcode);
    return (opcode == OPCODE_HALT);
  endfunction

endpackage

// File: rtl/stage_if_if.sv
// Handshake/bus bundle between the fetch stage and its neighbours
// (ID-stage targets, hazard unit, debug unit, IF/ID latch).
interface stage_if_if #(
  parameter int SIZE_REGISTER_INST = 32,
  parameter int SIZE_ADDR_PC       = 32,
  parameter int MEM_ADDR_W         = 8
);
  logic                          i_enable;
  logic                          i_stall;
  logic [1:0]                    i_pc_src;
  logic [SIZE_ADDR_PC-1:0]       i_branch_addr;
  logic [SIZE_ADDR_PC-1:0]       i_jump_addr;
  logic [SIZE_ADDR_PC-1:0]       i_jr_addr;
  logic                          i_inst_wr_en;
  logic [MEM_ADDR_W-1:0]         i_inst_wr_addr;
  logic [SIZE_REGISTER_INST-1:0] i_inst_wr_data;
  logic [SIZE_ADDR_PC-1:0]       o_pc;
  logic [SIZE_ADDR_PC-1:0]       o_next_pc;
  logic [SIZE_REGISTER_INST-1:0] o_instruction;
  logic                          o_halt;

  modport master (
    output i_enable, i_stall, i_pc_src, i_branch_addr, i_jump_addr, i_jr_addr,
           i_inst_wr_en, i_inst_wr_addr, i_inst_wr_data,
    input  o_pc, o_next_pc, o_instruction, o_halt
  );

  modport slave (
    input  i_enable, i_stall, i_pc_src, i_branch_addr, i_jump_addr, i_jr_addr,
           i_inst_wr_en, i_inst_wr_addr, i_inst_wr_data,
    output o_pc, o_next_pc, o_instruction, o_halt
  );
endinterface

// File: rtl/stage_if_instruction_memory.sv
// Instruction memory: asynchronous read, synchronous write from the debug
// unit. Contents are deliberately not reset so a loaded program survives.
module instruction_memory #(
  parameter int MEM_DEPTH          = 256,
  parameter int SIZE_REGISTER_INST = 32,
  localparam int ADDR_W            = $clog2(MEM_DEPTH)
) (
  input  logic                          i_clk,
  input  logic                          i_wr_en,
  input  logic [ADDR_W-1:0]             i_wr_addr,
  input  logic [SIZE_REGISTER_INST-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]             i_rd_addr,
  output logic [SIZE_REGISTER_INST-1:0] o_rd_data
);
  logic [SIZE_REGISTER_INST-1:0] mem [MEM_DEPTH];

  // Debug write port, updates the addressed word on the rising edge.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end else begin
      mem[i_wr_addr] <= mem[i_wr_addr];
    end
  end

  assign o_rd_data = mem[i_rd_addr];
endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Holds the PC, selects the next PC, reads instruction memory combinationally
// and freezes once a HALT word is fetched.
// Optional feature macro: IF_BRANCH_FLUSH_EN -- when defined, the delay-slot
// instruction is replaced by a NOP while a redirect is being presented.
module stage_if
  import mips_pkg::*;
#(
  parameter int SIZE_REGISTER_INST = 32,
  parameter int SIZE_ADDR_PC       = 32,
  parameter int MEM_DEPTH          = 256,
  parameter int MEM_ADDR_W         = 8
) (
  input logic       i_clk,
  input logic       i_reset,
  stage_if_if.slave bus
);
  logic [SIZE_ADDR_PC-1:0]       pc_r;
  logic                          halt_r;
  logic [SIZE_ADDR_PC-1:0]       next_pc;
  logic [SIZE_ADDR_PC-1:0]       target;
  logic [SIZE_REGISTER_INST-1:0] mem_word;
  logic [SIZE_REGISTER_INST-1:0] instruction;
  logic                          fetched_halt;

  instruction_memory #(
    .MEM_DEPTH          (MEM_DEPTH),
    .SIZE_REGISTER_INST (SIZE_REGISTER_INST)
  ) u_imem (
    .i_clk     (i_clk),
    .i_wr_en   (bus.i_inst_wr_en),
    .i_wr_addr (bus.i_inst_wr_addr),
    .i_wr_data (bus.i_inst_wr_data),
    .i_rd_addr (pc_r[MEM_ADDR_W+1:2]),
    .o_rd_data (mem_word)
  );

  // Sequential successor wraps naturally at the PC width.
  assign next_pc = pc_r + SIZE_ADDR_PC'(PC_INCREMENT);

  // Instruction presented to IF/ID; optionally squashes the delay slot.
  always_comb begin
    instruction = mem_word;
`ifdef IF_BRANCH_FLUSH_EN
    if ((bus.i_pc_src != PC_SRC_SEQ) && bus.i_enable) begin
      instruction = SIZE_REGISTER_INST'(INST_NOP);
    end else begin
      instruction = mem_word;
    end
`else
    instruction = mem_word;
`endif
  end

  // HALT detection sees the same word the IF/ID latch will capture.
  assign fetched_halt = is_halt_opcode(instruction[SIZE_REGISTER_INST-1 -: 6]);

  // Next-PC source mux.
  always_comb begin
    target = next_pc;
    case (pc_src_t'(bus.i_pc_src))
      PC_SRC_SEQ:    target = next_pc;
      PC_SRC_BRANCH: target = bus.i_branch_addr;
      PC_SRC_JUMP:   target = bus.i_jump_addr;
      PC_SRC_JR:     target = bus.i_jr_addr;
      default:       target = next_pc;
    endcase
  end

  // PC and sticky halt flag; holds in priority order halt, disable, stall.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc_r   <= {SIZE_ADDR_PC{1'b0}};
      halt_r <= 1'b0;
    end else if (halt_r || !bus.i_enable || bus.i_stall) begin
      pc_r   <= pc_r;
      halt_r <= halt_r;
    end else if (fetched_halt) begin
      pc_r   <= pc_r;
      halt_r <= 1'b1;
    end else begin
      pc_r   <= target;
      halt_r <= 1'b0;
    end
  end

  assign bus.o_pc          = pc_r;
  assign bus.o_next_pc     = next_pc;
  assign bus.o_instruction = instruction;
  assign bus.o_halt        = halt_r;
endmodule

// File: tb/tb_stage_if.sv
// Self-checking bench for stage_if: directed steps followed by a randomized
// run, compared against a behavioural model of the fetch stage.
module tb_stage_if;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [31:0] m_mem [256];
  logic [31:0] m_pc   = 32'd0;
  logic        m_halt = 1'b0;

  stage_if_if bus ();

  stage_if dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Word the model expects on the instruction output right now.
  function automatic logic [31:0] m_inst();
    logic [31:0] w;
    w = m_mem[(m_pc >> 2) % 256];
`ifdef IF_BRANCH_FLUSH_EN
    if (bus.i_pc_src != 2'b00 && bus.i_enable) w = 32'h0000_0000;
`endif
    return w;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    w[27] = 1'b0;
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},   bus.o_pc,          m_pc);
    check({tag, ".npc"},  bus.o_next_pc,     m_pc + 32'd4);
    check({tag, ".inst"}, bus.o_instruction, m_inst());
    check({tag, ".halt"}, 32'(bus.o_halt),   32'(m_halt));
  endtask

  // Advance one clock edge, updating the model from the pre-edge inputs.
  task automatic cycle();
    logic [31:0] inst;
    logic [31:0] npc;
    logic        nh;
    inst = m_inst();
    npc  = m_pc;
    nh   = m_halt;
    if (!rst) begin
      npc = 32'd0;
      nh  = 1'b0;
    end else if (!m_halt && bus.i_enable && !bus.i_stall) begin
      if (inst[31:26] == 6'b111111) nh = 1'b1;
      else if (bus.i_pc_src == 2'd0) npc = m_pc + 32'd4;
      else if (bus.i_pc_src == 2'd1) npc = bus.i_branch_addr;
      else if (bus.i_pc_src == 2'd2) npc = bus.i_jump_addr;
      else npc = bus.i_jr_addr;
    end
    @(posedge clk);
    if (bus.i_inst_wr_en) m_mem[bus.i_inst_wr_addr] = bus.i_inst_wr_data;
    m_pc   = npc;
    m_halt = nh;
    #1;
  endtask

  // Drop reset between edges and confirm it acts without a clock.
  task automatic reset_pulse(input string tag);
    #2;
    rst = 1'b0;
    #1;
    check({tag, ".async_pc"},   bus.o_pc,        32'd0);
    check({tag, ".async_halt"}, 32'(bus.o_halt), 32'd0);
    m_pc   = 32'd0;
    m_halt = 1'b0;
    check_all(tag);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    rst                = 1'b0;
    bus.i_enable       = 1'b0;
    bus.i_stall        = 1'b0;
    bus.i_pc_src       = 2'b00;
    bus.i_branch_addr  = 32'd0;
    bus.i_jump_addr    = 32'd0;
    bus.i_jr_addr      = 32'd0;
    bus.i_inst_wr_en   = 1'b1;
    bus.i_inst_wr_addr = 8'd0;
    bus.i_inst_wr_data = 32'd0;

    // Load the whole memory while held in reset.
    for (int i = 0; i < 256; i++) begin
      bus.i_inst_wr_addr = 8'(i);
      bus.i_inst_wr_data = (i < 4) ? 32'((i + 1) * 11) : rand_word();
      cycle();
    end
    bus.i_inst_wr_en = 1'b0;
    check("reset.pc",   bus.o_pc,          32'd0);
    check("reset.npc",  bus.o_next_pc,     32'd4);
    check("reset.inst", bus.o_instruction, 32'd11);
    check("reset.halt", 32'(bus.o_halt),   32'd0);

    // Sequential fetch.
    rst          = 1'b1;
    bus.i_enable = 1'b1;
    #1;
    check_all("seq0");
    cycle();
    check("seq1.pc", bus.o_pc, 32'd4);
    check("seq1.inst", bus.o_instruction, 32'd22);
    check_all("seq1");
    cycle();
    check("seq2.pc", bus.o_pc, 32'd8);
    check("seq2.inst", bus.o_instruction, 32'd33);

    // Stall two cycles, disable one, then resume.
    bus.i_stall = 1'b1;
    cycle();
    check("stall1.pc", bus.o_pc, 32'd8);
    cycle();
    check("stall2.pc", bus.o_pc, 32'd8);
    bus.i_stall  = 1'b0;
    bus.i_enable = 1'b0;
    cycle();
    check("disable.pc", bus.o_pc, 32'd8);
    bus.i_enable = 1'b1;
    cycle();
    check("resume.pc", bus.o_pc, 32'd12);
    check("resume.npc", bus.o_next_pc, 32'd16);
    check("resume.inst", bus.o_instruction, 32'd44);

    reset_pulse("midrst");

    // Next-PC selection.
    bus.i_pc_src      = 2'b01;
    bus.i_branch_addr = 32'h40;
    #1;
    check_all("br.pre");
    cycle();
    check("br.pc", bus.o_pc, 32'h40);
    bus.i_pc_src    = 2'b10;
    bus.i_jump_addr = 32'h80;
    check_all("jmp.pre");
    cycle();
    check("jmp.pc", bus.o_pc, 32'h80);
    bus.i_pc_src  = 2'b11;
    bus.i_jr_addr = 32'h10;
    check_all("jr.pre");
    cycle();
    check("jr.pc", bus.o_pc, 32'h10);
    bus.i_jr_addr = 32'hFFFF_FFFE;
    cycle();
    check("wrap.npc", bus.o_next_pc, 32'h0000_0002);
    bus.i_pc_src = 2'b00;
    #1;
    check("wrap.inst", bus.o_instruction, m_mem[255]);
    check_all("wrap");

    // HALT at word 2.
    bus.i_enable       = 1'b0;
    bus.i_inst_wr_en   = 1'b1;
    bus.i_inst_wr_addr = 8'd2;
    bus.i_inst_wr_data = 32'hFC00_0000;
    cycle();
    bus.i_inst_wr_en = 1'b0;
    reset_pulse("hltrst");
    bus.i_enable = 1'b1;
    cycle();
    cycle();
    check("hlt.fetch_pc", bus.o_pc, 32'd8);
    check("hlt.fetch_inst", bus.o_instruction, 32'hFC00_0000);
    cycle();
    check("hlt.pc", bus.o_pc, 32'd8);
    check("hlt.flag", 32'(bus.o_halt), 32'd1);
    bus.i_pc_src    = 2'b10;
    bus.i_jump_addr = 32'h80;
    cycle();
    cycle();
    check("hlt.hold_pc", bus.o_pc, 32'd8);
    check_all("hlt.hold");

    // Debug write at the current PC while disabled.
    bus.i_pc_src = 2'b00;
    reset_pulse("dbgrst");
    cycle();
    check("dbg.pc0", bus.o_pc, 32'd4);
    bus.i_enable       = 1'b0;
    bus.i_inst_wr_en   = 1'b1;
    bus.i_inst_wr_addr = 8'd1;
    bus.i_inst_wr_data = 32'hDEAD_BEEF;
    cycle();
    bus.i_inst_wr_en = 1'b0;
    check("dbg.inst", bus.o_instruction, 32'hDEAD_BEEF);
    check("dbg.pc", bus.o_pc, 32'd4);

    // Randomized run.
    for (int n = 0; n < 400; n++) begin
      rst                = ($urandom_range(0, 29) != 0);
      bus.i_enable       = ($urandom_range(0, 7) != 0);
      bus.i_stall        = ($urandom_range(0, 5) == 0);
      bus.i_pc_src       = 2'($urandom_range(0, 3));
      bus.i_branch_addr  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1023));
      bus.i_jump_addr    = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1023));
      bus.i_jr_addr      = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1023));
      bus.i_inst_wr_en   = ($urandom_range(0, 3) == 0);
      bus.i_inst_wr_addr = 8'($urandom_range(0, 255));
      d = rand_word();
      if ($urandom_range(0, 19) == 0) d[31:26] = 6'b111111;
      bus.i_inst_wr_data = d;
      #1;
      if (rst) check_all("rnd.comb");
      cycle();
      check_all("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
